// File: rtl/dac_burst_ctrl.sv
// ---------------------------------------------------------------------------
// dac_burst_ctrl
//
// Burst controller between the waveform batch source and the DAC channels.
// Processor burst requests are queued in a small FIFO. Each request streams
// exactly burst_size batches from the source to every DAC channel, applying
// a per-request arithmetic right shift and a channel enable mask. A
// burst_size of zero streams until halt. Back-to-back requests chain with no
// idle cycle between them.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   cfg_valid/ready   burst request handshake (ready = queue not full)
//   cfg_burst_size    batches in the burst, 0 = continuous
//   cfg_scale         right-shift amount, clamped to MAX_SCALE_FACTOR
//   cfg_chan_mask     per-channel enable, 1 = pass scaled data
//   halt              abort the running burst and flush the queue
//   src_data/valid/ready  source batch stream (channel c in slice c)
//   dac_data/valid    scaled and masked batch, one cycle after handshake
//   busy              controller is streaming a burst
//   burst_done        pulse alongside the last batch of a completed burst
//   req_count         number of queued requests
// ---------------------------------------------------------------------------
module dac_burst_ctrl #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int BATCH_SIZE       = 16,
  parameter int CHANNELS         = 8,
  parameter int BS_WIDTH         = 16,
  parameter int MAX_SCALE_FACTOR = 15,
  parameter int REQ_DEPTH        = 8,
  localparam int D  = CHANNELS * BATCH_SIZE * SAMPLE_WIDTH,
  localparam int SW = $clog2(MAX_SCALE_FACTOR + 1),
  localparam int CW = $clog2(REQ_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [BS_WIDTH-1:0] cfg_burst_size,
  input  logic [SW-1:0]       cfg_scale,
  input  logic [CHANNELS-1:0] cfg_chan_mask,
  input  logic                halt,
  input  logic [D-1:0]        src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [D-1:0]        dac_data,
  output logic                dac_valid,
  output logic                busy,
  output logic                burst_done,
  output logic [CW-1:0]       req_count
);

  localparam int PW = $clog2(REQ_DEPTH);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  // Shift amounts above the supported maximum are clamped when queued, so
  // the datapath never sees an out-of-range shift.
  function automatic logic [SW-1:0] sat_scale(input logic [SW-1:0] s);
    logic [31:0] s_wide;
    s_wide = 32'(s);
    if (s_wide > 32'(MAX_SCALE_FACTOR)) begin
      return SW'(MAX_SCALE_FACTOR);
    end
    return s;
  endfunction

  // Arithmetic right shift rounds toward -inf and can never overflow the
  // sample width; disabled channels output zero.
  function automatic logic signed [SAMPLE_WIDTH-1:0] scale_sample(
    input logic signed [SAMPLE_WIDTH-1:0] s,
    input logic        [SW-1:0]           sh,
    input logic                           en
  );
    if (!en) begin
      return '0;
    end
    return s >>> sh;
  endfunction

  // Request queue storage (data only, no reset needed).
  logic [BS_WIDTH-1:0] q_bs    [REQ_DEPTH];
  logic [SW-1:0]       q_scale [REQ_DEPTH];
  logic [CHANNELS-1:0] q_mask  [REQ_DEPTH];

  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       req_cnt;

  state_t              state;
  logic [BS_WIDTH-1:0] batch_cnt;

  // Active burst configuration, loaded on every pop.
  logic [BS_WIDTH-1:0] act_bs;
  logic [SW-1:0]       act_scale;
  logic [CHANNELS-1:0] act_mask;

  logic                q_empty;
  logic                push;
  logic                pop;
  logic                hs_p0;
  logic                last_p0;
  logic [D-1:0]        scaled_p0;

  logic [D-1:0]        data_p1;
  logic                vld_p1;
  logic                done_p1;

  assign q_empty   = (req_cnt == '0);
  // A full queue refuses pushes even when a pop happens in the same cycle.
  assign cfg_ready = !rst && (req_cnt < CW'(REQ_DEPTH));
  assign src_ready = !rst && !halt && (state == RUN);

  assign hs_p0   = src_valid && src_ready;
  assign last_p0 = hs_p0 && (act_bs != '0) &&
                   (batch_cnt == act_bs - BS_WIDTH'(1));

  // halt discards a simultaneous push and blocks any pop.
  assign push = cfg_valid && cfg_ready && !halt;
  assign pop  = !halt && !q_empty && ((state == IDLE) || last_p0);

  always_ff @(posedge clk) begin
    if (push) begin
      q_bs[wr_ptr]    <= cfg_burst_size;
      q_scale[wr_ptr] <= sat_scale(cfg_scale);
      q_mask[wr_ptr]  <= cfg_chan_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      act_bs    <= q_bs[rd_ptr];
      act_scale <= q_scale[rd_ptr];
      act_mask  <= q_mask[rd_ptr];
    end
  end

  // Control: FSM, queue pointers, batch counter, output-stage valid/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      batch_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      req_cnt   <= '0;
      vld_p1    <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      // hs_p0 is already low during halt, so a halt only stops new batches;
      // the batch sitting in the output stage still goes out.
      vld_p1  <= hs_p0;
      done_p1 <= last_p0;
      if (halt) begin
        state     <= IDLE;
        batch_cnt <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        req_cnt   <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        req_cnt <= req_cnt + CW'(push) - CW'(pop);
        case (state)
          IDLE: begin
            if (pop) begin
              state     <= RUN;
              batch_cnt <= '0;
            end
          end
          RUN: begin
            if (hs_p0) begin
              if (last_p0) begin
                // Chain straight into the next request when one is queued.
                batch_cnt <= '0;
                if (!pop) begin
                  state <= IDLE;
                end
              end else begin
                // Continuous bursts let the counter wrap freely.
                batch_cnt <= batch_cnt + BS_WIDTH'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    scaled_p0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int j = 0; j < BATCH_SIZE; j++) begin
        scaled_p0[(c*BATCH_SIZE + j)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
          scale_sample(src_data[(c*BATCH_SIZE + j)*SAMPLE_WIDTH +: SAMPLE_WIDTH],
                       act_scale, act_mask[c]);
      end
    end
  end

  // ---- stage p0 -> p1: register scaled batch on handshake ----
  always_ff @(posedge clk) begin
    if (hs_p0) begin
      data_p1 <= scaled_p0;
    end
  end

  // Data register is not reset; gating with the valid keeps the bus at zero
  // whenever nothing is being presented.
  assign dac_data   = vld_p1 ? data_p1 : '0;
  assign dac_valid  = vld_p1;
  assign burst_done = done_p1;
  assign busy       = (state == RUN);
  assign req_count  = req_cnt;

endmodule
